// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the programmable mod-M counter family.
// Direction/mode encodings match the up_dn and one_shot input polarities.
package mod_counter_pkg;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Smallest modulus that still produces a counting sequence.
  localparam int MOD_MIN = 2;

  function automatic logic [31:0] clamp_to_mod(input logic [31:0] value,
                                               input logic [31:0] mod);
    return (value >= mod) ? (mod - 32'd1) : value;
  endfunction

endpackage

// File: rtl/mod_m_counter_prog.sv
// Programmable mod-M up/down counter with load, wrap/one-shot modes and a
// shadowed modulus that is only committed on a wrap or a load.
module mod_m_counter_prog
  import mod_counter_pkg::*;
#(
  parameter int M = 12,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_dn,
  input  logic         one_shot,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         mod_wr,
  input  logic [N-1:0] mod_val,
  output logic [N-1:0] count,
  output logic         complete_tick,
  output logic         done,
  output logic         mod_err,
  output logic [N-1:0] mod_act
);

  logic [N-1:0] pending;
  logic         pending_valid;
  logic [N-1:0] mod_eff;
  logic [N-1:0] term_up;
  logic [N-1:0] step_next;
  logic         at_wrap;
  logic         advance;
  logic         hits_term;
  logic         commit;
  logic         mod_ok;

  always_comb begin
    mod_eff   = pending_valid ? pending : mod_act;
    term_up   = mod_act - 1'b1;
    at_wrap   = (up_dn == DIR_UP) ? (count >= term_up) : (count == '0);
    advance   = en && !done && !load;
    step_next = '0;
    if (up_dn == DIR_UP) begin
      step_next = at_wrap ? '0 : count + 1'b1;
    end else begin
      step_next = at_wrap ? mod_eff - 1'b1 : count - 1'b1;
    end
    // A wrap step never lands on the terminal value, so only plain steps can finish a one-shot.
    hits_term = (one_shot == MODE_ONESHOT) && !at_wrap &&
                ((up_dn == DIR_UP) ? (step_next == term_up) : (step_next == '0));
    commit    = load || (advance && at_wrap);
    mod_ok    = (mod_val >= N'(MOD_MIN));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      complete_tick <= 1'b0;
      done          <= 1'b0;
    end else begin
      complete_tick <= 1'b0;
      if (load) begin
        count <= N'(clamp_to_mod(32'(load_val), 32'(mod_eff)));
        done  <= 1'b0;
      end else if (advance) begin
        count         <= step_next;
        complete_tick <= at_wrap || hits_term;
        if (hits_term) done <= 1'b1;
      end
      if (one_shot == MODE_WRAP) done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mod_act       <= N'(M);
      pending       <= N'(M);
      pending_valid <= 1'b0;
      mod_err       <= 1'b0;
    end else begin
      mod_err <= mod_wr && !mod_ok;
      if (commit && pending_valid) begin
        mod_act       <= pending;
        pending_valid <= 1'b0;
      end
      // A write landing on the commit cycle stays pending for the next period.
      if (mod_wr && mod_ok) begin
        pending       <= mod_val;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule
